// File: rtl/lsu_bridge.sv
// lsu_bridge: load/store bridge from the MEM stage to an SRAM-like data bus
// (req/addr_ok/data_ok). Decodes load/store opcodes into bus size, byte
// strobes and replicated write data, runs one access at a time through an
// IDLE/ADDR/DATA/DRAIN/DONE machine, and returns the extended load result.
// Optional feature: define LSU_UNALIGNED_EXC_EN to raise adel_o/ades_o on
// misaligned accesses; otherwise addresses are forced to natural alignment.
module lsu_bridge #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  mem_req,
  input  logic [5:0]            op,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [31:0]           wdata,
  input  logic                  flush,
  output logic                  stall_o,
  output logic                  done_o,
  output logic [31:0]           rdata_o,
  output logic                  adel_o,
  output logic                  ades_o,
  output logic [ADDR_W-1:0]     badvaddr_o,
  output logic                  data_req,
  output logic                  data_wr,
  output logic [1:0]            data_size,
  output logic [DATA_W/8-1:0]   data_wstrb,
  output logic [ADDR_W-1:0]     data_addr,
  output logic [DATA_W-1:0]     data_wdata,
  input  logic                  data_addr_ok,
  input  logic                  data_data_ok,
  input  logic [DATA_W-1:0]     data_rdata
);
  localparam int NL   = DATA_W / 8;
  localparam int LN_W = $clog2(NL);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [5:0]        op_q;
  logic              wr_q;
  logic [1:0]        size_q;
  logic [NL-1:0]     wstrb_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [31:0]       rdata_q;

  logic              op_valid, op_load;
  logic [1:0]        op_size;
  logic              addr_err;
  logic [ADDR_W-1:0] acc_addr;
  logic [LN_W-1:0]   lane;
  logic [NL-1:0]     strb_base;
  logic [DATA_W-1:0] wdata_rep;
  logic              accept;
  logic [31:0]       rd_word;
  logic [31:0]       rd_ext;
  logic              ld_signed;

  // Opcode decode: validity, direction and access size
  always_comb begin
    op_valid = 1'b1;
    op_load  = 1'b1;
    op_size  = 2'd2;
    case (op)
      OP_LB, OP_LBU: op_size = 2'd0;
      OP_LH, OP_LHU: op_size = 2'd1;
      OP_LW:         op_size = 2'd2;
      OP_SB:         begin op_load = 1'b0; op_size = 2'd0; end
      OP_SH:         begin op_load = 1'b0; op_size = 2'd1; end
      OP_SW:         begin op_load = 1'b0; op_size = 2'd2; end
      default:       op_valid = 1'b0;
    endcase
  end

`ifdef LSU_UNALIGNED_EXC_EN
  logic misaligned;
  assign misaligned = ((op_size == 2'd1) && addr[0]) ||
                      ((op_size == 2'd2) && (addr[1:0] != 2'b00));
  // Errors are only reported while idle, so an in-flight access never faults
  assign addr_err   = (state_q == S_IDLE) && mem_req && op_valid && misaligned;
  assign adel_o     = addr_err && op_load;
  assign ades_o     = addr_err && !op_load;
  assign badvaddr_o = addr_err ? addr : '0;
  assign acc_addr   = addr;
`else
  assign addr_err   = 1'b0;
  assign adel_o     = 1'b0;
  assign ades_o     = 1'b0;
  assign badvaddr_o = '0;
  // Force natural alignment by clearing the low address bits
  always_comb begin
    acc_addr = addr;
    if (op_size == 2'd1) acc_addr[0] = 1'b0;
    if (op_size == 2'd2) acc_addr[1:0] = 2'b00;
  end
`endif

  assign lane = acc_addr[LN_W-1:0];

  // Strobe pattern for the access size before shifting to its lane
  always_comb begin
    case (op_size)
      2'd0:    strb_base = NL'(4'h1);
      2'd1:    strb_base = NL'(4'h3);
      default: strb_base = NL'(4'hF);
    endcase
  end

  // Each byte lane takes the source byte it would hold for its own alignment
  for (genvar gi = 0; gi < NL; gi++) begin : g_rep
    assign wdata_rep[8*gi +: 8] = (op_size == 2'd0) ? wdata[7:0] :
                                  (op_size == 2'd1) ? wdata[8*(gi%2) +: 8] :
                                                      wdata[8*(gi%4) +: 8];
  end

  assign accept = (state_q == S_IDLE) && mem_req && op_valid && !addr_err && !flush;

  // Next-state logic, including flush handling for abandoned accesses
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_ADDR;
      S_ADDR: begin
        if (flush)             state_d = data_addr_ok ? S_DRAIN : S_IDLE;
        else if (data_addr_ok) state_d = S_DATA;
      end
      S_DATA: begin
        // A response arriving with the flush already completes the access
        if (flush)             state_d = data_data_ok ? S_IDLE : S_DRAIN;
        else if (data_data_ok) state_d = S_DONE;
      end
      S_DRAIN: if (data_data_ok) state_d = S_IDLE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pick the addressed lane from the bus word and extend it
  assign rd_word   = 32'(data_rdata >> {addr_q[LN_W-1:0], 3'b000});
  assign ld_signed = (op_q == OP_LB) || (op_q == OP_LH);
  always_comb begin
    case (size_q)
      2'd0:    rd_ext = {{24{ld_signed & rd_word[7]}},  rd_word[7:0]};
      2'd1:    rd_ext = {{16{ld_signed & rd_word[15]}}, rd_word[15:0]};
      default: rd_ext = rd_word;
    endcase
    if (wr_q) rd_ext = 32'h0;
  end

  // State, captured request fields and load result
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      wr_q    <= 1'b0;
      size_q  <= '0;
      wstrb_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= op;
        wr_q    <= !op_load;
        size_q  <= op_size;
        wstrb_q <= op_load ? '0 : (strb_base << lane);
        addr_q  <= acc_addr;
        wdata_q <= wdata_rep;
      end
      if ((state_q == S_DATA) && data_data_ok && !flush) rdata_q <= rd_ext;
    end
  end

  assign data_req   = (state_q == S_ADDR);
  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_wstrb = wstrb_q;
  assign data_addr  = addr_q;
  assign data_wdata = wdata_q;
  assign rdata_o    = rdata_q;
  assign done_o     = (state_q == S_DONE) && !flush;
  assign stall_o    = ((state_q == S_IDLE) && mem_req && op_valid && !addr_err) ||
                      (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_DRAIN);

endmodule

// File: tb/tb_lsu_bridge.sv
// tb_lsu_bridge: scoreboard bench for lsu_bridge with a 32-bit and a 64-bit
// instance driven by the same pipeline and handshake inputs.
module tb_lsu_bridge;
  localparam logic [5:0] LB  = 6'h20;
  localparam logic [5:0] LH  = 6'h21;
  localparam logic [5:0] LW  = 6'h23;
  localparam logic [5:0] LBU = 6'h24;
  localparam logic [5:0] LHU = 6'h25;
  localparam logic [5:0] SB  = 6'h28;
  localparam logic [5:0] SH  = 6'h29;
  localparam logic [5:0] SW  = 6'h2B;

  typedef struct {
    logic [5:0]  op;   logic [31:0] addr; logic [31:0] wd;
    int          aw;   int          dw;
    logic [31:0] rd32; logic [63:0] rd64;
    logic        wr;   logic [1:0]  size; logic [31:0] baddr;
    logic [3:0]  s32;  logic [31:0] w32;  logic [7:0]  s64; logic [63:0] w64;
    logic [31:0] r32;  logic [31:0] r64;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, mem_req, flush, data_addr_ok, data_data_ok;
  logic [5:0]  op;
  logic [31:0] addr, wdata, rdata32;
  logic [63:0] rdata64;

  logic        stall32, done32, adel32, ades32, req32, wr32;
  logic [31:0] rd_o32, badv32, daddr32, dwdata32;
  logic [1:0]  size32;
  logic [3:0]  strb32;
  logic        stall64, done64, adel64, ades64, req64, wr64;
  logic [31:0] rd_o64, badv64, daddr64;
  logic [63:0] dwdata64;
  logic [1:0]  size64;
  logic [7:0]  strb64;

  lsu_bridge #(.DATA_W(32), .ADDR_W(32)) u32 (
    .clk(clk), .resetn(resetn), .mem_req(mem_req), .op(op), .addr(addr), .wdata(wdata),
    .flush(flush), .stall_o(stall32), .done_o(done32), .rdata_o(rd_o32),
    .adel_o(adel32), .ades_o(ades32), .badvaddr_o(badv32),
    .data_req(req32), .data_wr(wr32), .data_size(size32), .data_wstrb(strb32),
    .data_addr(daddr32), .data_wdata(dwdata32), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(rdata32));

  lsu_bridge #(.DATA_W(64), .ADDR_W(32)) u64 (
    .clk(clk), .resetn(resetn), .mem_req(mem_req), .op(op), .addr(addr), .wdata(wdata),
    .flush(flush), .stall_o(stall64), .done_o(done64), .rdata_o(rd_o64),
    .adel_o(adel64), .ades_o(ades64), .badvaddr_o(badv64),
    .data_req(req64), .data_wr(wr64), .data_size(size64), .data_wstrb(strb64),
    .data_addr(daddr64), .data_wdata(dwdata64), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(rdata64));

  int checks_cnt = 0;
  int errors_cnt = 0;
  logic [31:0] q32[$];
  logic [31:0] q64[$];
  logic [31:0] e32, e64;
  vec_t vecs[9];
  vec_t v;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: every done pulse pops one expected load result
  always @(negedge clk) begin
    if (done32) begin
      if (q32.size() == 0) check_val("unexp_done32", 64'(done32), 64'd0);
      else begin
        e32 = q32.pop_front();
        check_val("rdata32", 64'(rd_o32), 64'(e32));
      end
    end
    if (done64) begin
      if (q64.size() == 0) check_val("unexp_done64", 64'(done64), 64'd0);
      else begin
        e64 = q64.pop_front();
        check_val("rdata64", 64'(rd_o64), 64'(e64));
      end
    end
  end

  // Runs one access; called and returns just after a rising edge
  task automatic run_vec(input vec_t t);
    mem_req = 1'b1; op = t.op; addr = t.addr; wdata = t.wd;
    rdata32 = t.rd32; rdata64 = t.rd64;
    q32.push_back(t.r32);
    q64.push_back(t.r64);
    @(negedge clk);
    check_val("stall_accept", 64'(stall32), 64'd1);
    check_val("no_exc", 64'({adel32, ades32, badv32}), 64'd0);
    @(posedge clk); #1;
    for (int i = 0; i <= t.aw; i++) begin
      data_addr_ok = (i == t.aw);
      @(negedge clk);
      check_val("req32", 64'(req32), 64'd1);
      check_val("req64", 64'(req64), 64'd1);
      check_val("stall_addr", 64'(stall32), 64'd1);
      check_val("wr", 64'(wr32), 64'(t.wr));
      check_val("size", 64'({size32, size64}), 64'({t.size, t.size}));
      check_val("addr", 64'({daddr32, daddr64}), {t.baddr, t.baddr});
      check_val("strb32", 64'(strb32), 64'(t.s32));
      check_val("wdata32", 64'(dwdata32), 64'(t.w32));
      check_val("strb64", 64'(strb64), 64'(t.s64));
      check_val("wdata64", dwdata64, t.w64);
      @(posedge clk); #1;
    end
    data_addr_ok = 1'b0;
    for (int i = 0; i <= t.dw; i++) begin
      data_data_ok = (i == t.dw);
      @(negedge clk);
      check_val("req_data", 64'(req32), 64'd0);
      check_val("stall_data", 64'(stall32), 64'd1);
      check_val("done_early", 64'(done32), 64'd0);
      @(posedge clk); #1;
    end
    data_data_ok = 1'b0;
    @(negedge clk);
    check_val("done32", 64'(done32), 64'd1);
    check_val("done64", 64'(done64), 64'd1);
    check_val("stall_done", 64'(stall32), 64'd0);
    $display("txn op=%h addr=%h aw=%0d dw=%0d rdata32=%h rdata64=%h", t.op, t.addr, t.aw, t.dw, rd_o32, rd_o64);
    @(posedge clk); #1;
    mem_req = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; mem_req = 1'b0; flush = 1'b0; op = '0; addr = '0; wdata = '0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; rdata32 = '0; rdata64 = '0;

    //            op   addr        wd            aw dw rd32          rd64                    wr    size  baddr       s32   w32           s64    w64                     r32           r64
    vecs[0] = '{LB,  32'h1003, 32'h0,        0, 0, 32'h80FF1234, 64'h00000000_80FF1234, 1'b0, 2'd0, 32'h1003, 4'h0, 32'h0,        8'h00, 64'h0,                  32'hFFFFFF80, 32'hFFFFFF80};
    vecs[1] = '{LBU, 32'h1003, 32'h0,        0, 0, 32'h80FF1234, 64'h00000000_80FF1234, 1'b0, 2'd0, 32'h1003, 4'h0, 32'h0,        8'h00, 64'h0,                  32'h00000080, 32'h00000080};
    vecs[2] = '{LH,  32'h1002, 32'h0,        1, 1, 32'h80FF1234, 64'h00000000_80FF1234, 1'b0, 2'd1, 32'h1002, 4'h0, 32'h0,        8'h00, 64'h0,                  32'hFFFF80FF, 32'hFFFF80FF};
    vecs[3] = '{LHU, 32'h1000, 32'h0,        0, 2, 32'h80FF8234, 64'h00000000_80FF8234, 1'b0, 2'd1, 32'h1000, 4'h0, 32'h0,        8'h00, 64'h0,                  32'h00008234, 32'h00008234};
    vecs[4] = '{LW,  32'h0004, 32'h0,        0, 0, 32'hCAFEBABE, 64'h11223344_55667788, 1'b0, 2'd2, 32'h0004, 4'h0, 32'h0,        8'h00, 64'h0,                  32'hCAFEBABE, 32'h11223344};
    vecs[5] = '{SH,  32'h2002, 32'h0000ABCD, 2, 1, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b1, 2'd1, 32'h2002, 4'hC, 32'hABCDABCD, 8'h0C, 64'hABCDABCD_ABCDABCD, 32'h0,        32'h0};
    vecs[6] = '{SB,  32'h300D, 32'h123456A5, 1, 0, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b1, 2'd0, 32'h300D, 4'h2, 32'hA5A5A5A5, 8'h20, 64'hA5A5A5A5_A5A5A5A5, 32'h0,        32'h0};
    vecs[7] = '{SW,  32'h4004, 32'h12345678, 0, 2, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b1, 2'd2, 32'h4004, 4'hF, 32'h12345678, 8'hF0, 64'h12345678_12345678, 32'h0,        32'h0};
    vecs[8] = '{LB,  32'h5006, 32'h0,        0, 0, 32'h007F0000, 64'h00AA7F00_00000000, 1'b0, 2'd0, 32'h5006, 4'h0, 32'h0,        8'h00, 64'h0,                  32'h0000007F, 32'hFFFFFFAA};

    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check_val("rst_rdata", 64'({rd_o32, rd_o64}), 64'd0);
    check_val("rst_ctrl", 64'({req32, stall32, done32, wr32, size32, strb32, adel32, ades32}), 64'd0);
    check_val("rst_bus32", {daddr32, dwdata32}, 64'd0);
    check_val("rst_bus64", dwdata64 | 64'(daddr64) | 64'(strb64) | 64'(badv32), 64'd0);
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(vecs[i]);

`ifdef LSU_UNALIGNED_EXC_EN
    // Misaligned accesses fault in the same cycle and never reach the bus
    mem_req = 1'b1; op = LW; addr = 32'h0000_0002;
    @(negedge clk);
    check_val("adel", 64'({adel32, ades32, adel64, ades64}), 64'b1010);
    check_val("badv_lw", 64'({badv32, badv64}), {32'h2, 32'h2});
    check_val("stall_exc", 64'({stall32, stall64}), 64'd0);
    @(posedge clk); #1;
    op = SH; addr = 32'h0000_2003;
    @(negedge clk);
    check_val("ades", 64'({adel32, ades32}), 64'b01);
    check_val("badv_sh", 64'(badv32), 64'h2003);
    @(posedge clk); #1;
    mem_req = 1'b0;
    @(negedge clk);
    check_val("req_exc", 64'({req32, req64}), 64'd0);
    @(posedge clk); #1;
`else
    // Misaligned LW is aligned down and performed
    v = '{LW, 32'h0002, 32'h0, 0, 0, 32'hDEADBEEF, 64'h00000000_DEADBEEF, 1'b0, 2'd2, 32'h0000, 4'h0, 32'h0, 8'h00, 64'h0, 32'hDEADBEEF, 32'hDEADBEEF};
    run_vec(v);
`endif

    // Unknown opcode: no stall, no request
    mem_req = 1'b1; op = 6'h3F; addr = 32'h100;
    @(negedge clk);
    check_val("badop_stall", 64'(stall32), 64'd0);
    @(posedge clk); #1;
    mem_req = 1'b0;
    @(negedge clk);
    check_val("badop_req", 64'(req32), 64'd0);
    @(posedge clk); #1;

    // Flush in IDLE blocks acceptance
    mem_req = 1'b1; op = LW; addr = 32'h60; flush = 1'b1;
    @(posedge clk); #1;
    mem_req = 1'b0; flush = 1'b0;
    @(negedge clk);
    check_val("flush_idle_req", 64'(req32), 64'd0);
    @(posedge clk); #1;

    // Flush in ADDR without addr_ok drops the request
    mem_req = 1'b1; op = LW; addr = 32'h30;
    @(posedge clk); #1;
    flush = 1'b1; mem_req = 1'b0;
    @(negedge clk);
    check_val("flush_addr_req", 64'(req32), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check_val("flush_addr_idle", 64'({req32, stall32}), 64'd0);
    @(posedge clk); #1;

    // Flush in DATA: drain until data_ok three cycles later, then accept
    mem_req = 1'b1; op = LW; addr = 32'h10; rdata32 = 32'h55555555;
    @(posedge clk); #1;
    data_addr_ok = 1'b1;
    @(posedge clk); #1;
    data_addr_ok = 1'b0; flush = 1'b1; mem_req = 1'b0;
    @(negedge clk);
    check_val("flush_data_stall", 64'(stall32), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_data_ok = (i == 2);
      @(negedge clk);
      check_val("drain_stall", 64'(stall32), 64'd1);
      check_val("drain_req", 64'(req32), 64'd0);
      @(posedge clk); #1;
    end
    data_data_ok = 1'b0;
    v = '{LW, 32'h0020, 32'h0, 0, 0, 32'h0BADF00D, 64'h0BADF00D_00C0FFEE, 1'b0, 2'd2, 32'h0020, 4'h0, 32'h0, 8'h00, 64'h0, 32'h0BADF00D, 32'h00C0FFEE};
    run_vec(v);

    // Flush in DONE suppresses done_o
    mem_req = 1'b1; op = LW; addr = 32'h40; rdata32 = 32'h13572468; rdata64 = 64'h13572468;
    @(posedge clk); #1;
    data_addr_ok = 1'b1;
    @(posedge clk); #1;
    data_addr_ok = 1'b0; data_data_ok = 1'b1;
    @(posedge clk); #1;
    data_data_ok = 1'b0; flush = 1'b1;
    @(negedge clk);
    check_val("flush_done", 64'({done32, done64, stall32}), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; mem_req = 1'b0;

    // Reset during ADDR abandons the access and clears every output
    mem_req = 1'b1; op = SW; addr = 32'h70; wdata = 32'h89ABCDEF;
    @(posedge clk); #1;
    resetn = 1'b0; mem_req = 1'b0;
    @(negedge clk);
    check_val("rst_pre_req", 64'(req32), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("rst_mid_ctrl", 64'({req32, req64, stall32, done32, wr32, size32, strb32}), 64'd0);
    check_val("rst_mid_rdata", 64'({rd_o32, rd_o64}), 64'd0);
    check_val("rst_mid_bus", {daddr32, dwdata32}, 64'd0);
    check_val("rst_mid_bus64", dwdata64, 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    check_val("q32_empty", 64'(q32.size()), 64'd0);
    check_val("q64_empty", 64'(q64.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end
endmodule
